// File: rtl/rv32i_data_port.sv
// Data-side memory responder for the RV32I core: word RAM window plus a small MMIO bank.
// Optional timer compare register and irq are built when RV32I_DPORT_TIMER_EN is defined.
module rv32i_data_port #(
   parameter logic [31:0] RAM_BASE  = 32'h0000_2000,
   parameter int unsigned RAM_WORDS = 2048,
   parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Memwrite,
   input  logic [31:0] Memaddr,
   input  logic [31:0] MemWdata,
   output logic [31:0] MemRdata,
   input  logic [15:0] sw_in,
   output logic [15:0] led_out,
   output logic        irq,
   output logic        addr_err
);

   localparam int unsigned AW = $clog2(RAM_WORDS);

   logic [31:0]   ram [RAM_WORDS];
   logic [31:0]   ram_off;
   logic [AW-1:0] ram_idx;
   logic          ram_hit;
   logic          mmio_hit;
   logic [1:0]    mmio_off;
   logic          unused_off_bits;

   logic [15:0] led_q, led_d;
   logic [15:0] sw_meta_q, sw_sync_q;
   logic [31:0] cycle_q, cycle_d;
   logic        addr_err_q, addr_err_d;
   logic [31:0] tcmp_rd;

   // Unsigned wraparound makes addresses below RAM_BASE fall outside the window.
   assign ram_off         = Memaddr - RAM_BASE;
   assign ram_hit         = (ram_off >> 2) < 32'(RAM_WORDS);
   assign ram_idx         = ram_off[AW+1:2];
   assign mmio_hit        = !ram_hit && (Memaddr[31:4] == MMIO_BASE[31:4]);
   assign mmio_off        = Memaddr[3:2];
   assign unused_off_bits = ^ram_off[1:0];

   always_ff @(posedge clk) begin
      if (Memwrite && !reset && ram_hit) begin
         ram[ram_idx] <= MemWdata;
      end
   end

   always_comb begin
      led_d      = led_q;
      cycle_d    = cycle_q + 32'd1;
      addr_err_d = addr_err_q;
      if (Memwrite) begin
         if (mmio_hit) begin
            unique case (mmio_off)
               2'd0:    led_d   = MemWdata[15:0];
               2'd2:    cycle_d = MemWdata;
               default: ;
            endcase
         end else if (!ram_hit) begin
            addr_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led_q      <= '0;
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
         cycle_q    <= '0;
         addr_err_q <= 1'b0;
      end else begin
         led_q      <= led_d;
         sw_meta_q  <= sw_in;
         sw_sync_q  <= sw_meta_q;
         cycle_q    <= cycle_d;
         addr_err_q <= addr_err_d;
      end
   end

`ifdef RV32I_DPORT_TIMER_EN
   logic [31:0] tcmp_q, tcmp_d;
   logic        irq_q, irq_d;
   logic        tcmp_we;
   logic        match;

   assign tcmp_we = Memwrite && mmio_hit && (mmio_off == 2'd3);
   // Compare uses the pre-write CYCLE value; a TCMP write always clears irq.
   assign match   = (cycle_q == tcmp_q) && (tcmp_q != 32'd0);

   always_comb begin
      tcmp_d = tcmp_q;
      irq_d  = irq_q;
      if (tcmp_we) begin
         tcmp_d = MemWdata;
         irq_d  = 1'b0;
      end else if (match) begin
         irq_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tcmp_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         tcmp_q <= tcmp_d;
         irq_q  <= irq_d;
      end
   end

   assign tcmp_rd = tcmp_q;
   assign irq     = irq_q;
`else
   assign tcmp_rd = 32'd0;
   assign irq     = 1'b0;
`endif

   always_comb begin
      MemRdata = 32'd0;
      if (ram_hit) begin
         MemRdata = ram[ram_idx];
      end else if (mmio_hit) begin
         unique case (mmio_off)
            2'd0:    MemRdata = {16'd0, led_q};
            2'd1:    MemRdata = {16'd0, sw_sync_q};
            2'd2:    MemRdata = cycle_q;
            default: MemRdata = tcmp_rd;
         endcase
      end
   end

   assign led_out  = led_q;
   assign addr_err = addr_err_q;

endmodule
